// File: rtl/tomasulo_pkg.sv
// Shared types and opcode decode for the Tomasulo issue stage.
package tomasulo_pkg;

  // Storage widths for the shared structs; module parameters must not exceed these.
  localparam int unsigned MAX_FUNC_W = 8;
  localparam int unsigned MAX_REG_W  = 8;
  localparam int unsigned MAX_ROB_IW = 8;

  localparam logic [MAX_FUNC_W-1:0] OP_ADD = 8'h00;
  localparam logic [MAX_FUNC_W-1:0] OP_SUB = 8'h01;
  localparam logic [MAX_FUNC_W-1:0] OP_MUL = 8'h02;
  localparam logic [MAX_FUNC_W-1:0] OP_DIV = 8'h03;

  typedef enum logic [1:0] {FU_ADD, FU_MUL, FU_ILL} fu_class_e;

  typedef struct packed {
    logic [MAX_FUNC_W-1:0] func;
    logic [MAX_REG_W-1:0]  rd;
  } rob_entry_t;

  typedef struct packed {
    logic                  busy;
    logic [MAX_ROB_IW-1:0] tag;
  } rename_entry_t;

  function automatic fu_class_e fu_class(input logic [MAX_FUNC_W-1:0] func);
    case (func)
      OP_ADD, OP_SUB: return FU_ADD;
      OP_MUL, OP_DIV: return FU_MUL;
      default:        return FU_ILL;
    endcase
  endfunction

endpackage

// File: rtl/tomasulo_issue_unit_if.sv
// Issue-stage bus: decoded instruction in, feedback in, issue bundle and status out.
interface tomasulo_issue_unit_if #(
  parameter int unsigned ROB_IW = 3,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned FUNC_W = 4
);
  logic              inst_valid;
  logic              inst_ready;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic [REG_W-1:0]  rd;
  logic [FUNC_W-1:0] func;
  logic              add_rel;
  logic              mul_rel;
  logic              commit_valid;
  logic              flush;
  logic              iss_valid;
  logic [ROB_IW-1:0] iss_rob_idx;
  logic [FUNC_W-1:0] iss_func;
  logic [REG_W-1:0]  iss_rd;
  logic              iss_rs1_busy;
  logic              iss_rs2_busy;
  logic [ROB_IW-1:0] iss_rs1_tag;
  logic [ROB_IW-1:0] iss_rs2_tag;
  logic [REG_W-1:0]  iss_rs1;
  logic [REG_W-1:0]  iss_rs2;
  logic              illegal_op;
  logic [ROB_IW-1:0] rob_head;
  logic [ROB_IW-1:0] rob_tail;
  logic [ROB_IW:0]   rob_count;
  logic              stall;

  modport master (
    output inst_valid, rs1, rs2, rd, func, add_rel, mul_rel, commit_valid, flush,
    input  inst_ready, iss_valid, iss_rob_idx, iss_func, iss_rd, iss_rs1_busy, iss_rs2_busy,
           iss_rs1_tag, iss_rs2_tag, iss_rs1, iss_rs2, illegal_op, rob_head, rob_tail,
           rob_count, stall
  );

  modport slave (
    input  inst_valid, rs1, rs2, rd, func, add_rel, mul_rel, commit_valid, flush,
    output inst_ready, iss_valid, iss_rob_idx, iss_func, iss_rd, iss_rs1_busy, iss_rs2_busy,
           iss_rs1_tag, iss_rs2_tag, iss_rs1, iss_rs2, illegal_op, rob_head, rob_tail,
           rob_count, stall
  );
endinterface

// File: rtl/rename_table.sv
// Register rename table: two async read ports, one write, tag-matched clear, flush.
module rename_table
  import tomasulo_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ROB_IW   = 3,
  parameter int unsigned REG_W    = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [REG_W-1:0]  rd1_idx_i,
  output rename_entry_t     rd1_o,
  input  logic [REG_W-1:0]  rd2_idx_i,
  output rename_entry_t     rd2_o,
  input  logic              we_i,
  input  logic [REG_W-1:0]  wr_idx_i,
  input  logic [ROB_IW-1:0] wr_tag_i,
  input  logic              clr_i,
  input  logic [REG_W-1:0]  clr_idx_i,
  input  logic [ROB_IW-1:0] clr_tag_i
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ROB_IW-1:0]   tag_q [NUM_REGS];
  logic [ROB_IW-1:0]   tag_d [NUM_REGS];

  // Next state: flush wins; the issue write is applied after the clear so it overrides it.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      // Only clear if no younger instruction has re-renamed this register.
      if (clr_i && (tag_q[clr_idx_i] == clr_tag_i)) busy_d[clr_idx_i] = 1'b0;
      if (we_i) begin
        busy_d[wr_idx_i] = 1'b1;
        tag_d[wr_idx_i]  = wr_tag_i;
      end
    end
  end

  // Read ports see the state before this edge's update.
  always_comb begin
    rd1_o = '{busy: busy_q[rd1_idx_i], tag: MAX_ROB_IW'(tag_q[rd1_idx_i])};
    rd2_o = '{busy: busy_q[rd2_idx_i], tag: MAX_ROB_IW'(tag_q[rd2_idx_i])};
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) tag_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

endmodule

// File: rtl/tomasulo_issue_unit.sv
// Tomasulo issue stage: ROB allocation, renaming, RS slot accounting, registered issue bundle.
module tomasulo_issue_unit
  import tomasulo_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = 8,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned FUNC_W    = 4,
  parameter int unsigned ADD_RS    = 2,
  parameter int unsigned MUL_RS    = 2
) (
  input logic                  clk1,
  input logic                  rst_n,
  tomasulo_issue_unit_if.slave bus
);

  localparam int unsigned ROB_IW = $clog2(ROB_DEPTH);
  localparam int unsigned REG_W  = $clog2(NUM_REGS);
  localparam int unsigned ADD_CW = $clog2(ADD_RS + 1);
  localparam int unsigned MUL_CW = $clog2(MUL_RS + 1);
  localparam logic [ROB_IW:0]   ROB_FULL = (ROB_IW + 1)'(ROB_DEPTH);
  localparam logic [ADD_CW-1:0] ADD_MAX  = ADD_CW'(ADD_RS);
  localparam logic [MUL_CW-1:0] MUL_MAX  = MUL_CW'(MUL_RS);

  logic [ROB_IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_IW:0]   count_q, count_d;
  logic [ADD_CW-1:0] add_cnt_q, add_cnt_d;
  logic [MUL_CW-1:0] mul_cnt_q, mul_cnt_d;
  rob_entry_t        rob_q [ROB_DEPTH];

  fu_class_e         cls;
  logic              inst_ready, full, fire, ill_fire, commit, add_inc, mul_inc;
  rename_entry_t     src1, src2;
  logic [REG_W-1:0]  commit_rd;
  logic              unused_bits;

  logic              iss_valid_q, illegal_q, iss_rs1_busy_q, iss_rs2_busy_q;
  logic [ROB_IW-1:0] iss_rob_idx_q, iss_rs1_tag_q, iss_rs2_tag_q;
  logic [FUNC_W-1:0] iss_func_q;
  logic [REG_W-1:0]  iss_rd_q, iss_rs1_q, iss_rs2_q;

  // Readiness from registered state only; releases and commits this cycle are not bypassed.
  always_comb begin
    cls        = fu_class(MAX_FUNC_W'(bus.func));
    full       = (count_q == ROB_FULL);
    inst_ready = 1'b0;
    if (!bus.flush) begin
      case (cls)
        FU_ADD:  inst_ready = !full && (add_cnt_q < ADD_MAX);
        FU_MUL:  inst_ready = !full && (mul_cnt_q < MUL_MAX);
        default: inst_ready = 1'b1;
      endcase
    end
    fire      = bus.inst_valid && inst_ready && (cls != FU_ILL);
    ill_fire  = bus.inst_valid && inst_ready && (cls == FU_ILL);
    add_inc   = fire && (cls == FU_ADD);
    mul_inc   = fire && (cls == FU_MUL);
    commit    = bus.commit_valid && (count_q != '0) && !bus.flush;
    commit_rd = REG_W'(rob_q[head_q].rd);
  end

  // Pointer and counter next state; flush overrides everything.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    add_cnt_d = add_cnt_q;
    mul_cnt_d = mul_cnt_q;
    if (bus.flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      add_cnt_d = '0;
      mul_cnt_d = '0;
    end else begin
      if (fire)   tail_d = tail_q + 1'b1;
      if (commit) head_d = head_q + 1'b1;
      if (fire && !commit)      count_d = count_q + 1'b1;
      else if (!fire && commit) count_d = count_q - 1'b1;
      if (add_inc && !bus.add_rel) add_cnt_d = add_cnt_q + 1'b1;
      else if (!add_inc && bus.add_rel && (add_cnt_q != '0)) add_cnt_d = add_cnt_q - 1'b1;
      if (mul_inc && !bus.mul_rel) mul_cnt_d = mul_cnt_q + 1'b1;
      else if (!mul_inc && bus.mul_rel && (mul_cnt_q != '0)) mul_cnt_d = mul_cnt_q - 1'b1;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      add_cnt_q <= '0;
      mul_cnt_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      add_cnt_q <= add_cnt_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // ROB payload; entries are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk1) begin
    if (fire) rob_q[tail_q] <= '{func: MAX_FUNC_W'(bus.func), rd: MAX_REG_W'(bus.rd)};
  end

  // Func is stored for the ROB's consumers and the struct fields are wider than used here.
  always_comb begin
    unused_bits = ^{src1, src2};
    for (int i = 0; i < ROB_DEPTH; i++) unused_bits = unused_bits ^ (^rob_q[i]);
  end

  rename_table #(
    .NUM_REGS (NUM_REGS),
    .ROB_IW   (ROB_IW),
    .REG_W    (REG_W)
  ) u_rename (
    .clk_i     (clk1),
    .rst_ni    (rst_n),
    .flush_i   (bus.flush),
    .rd1_idx_i (bus.rs1),
    .rd1_o     (src1),
    .rd2_idx_i (bus.rs2),
    .rd2_o     (src2),
    .we_i      (fire),
    .wr_idx_i  (bus.rd),
    .wr_tag_i  (tail_q),
    .clr_i     (commit),
    .clr_idx_i (commit_rd),
    .clr_tag_i (head_q)
  );

  // Registered issue bundle and illegal-op pulse.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q    <= 1'b0;
      illegal_q      <= 1'b0;
      iss_rob_idx_q  <= '0;
      iss_func_q     <= '0;
      iss_rd_q       <= '0;
      iss_rs1_q      <= '0;
      iss_rs2_q      <= '0;
      iss_rs1_busy_q <= 1'b0;
      iss_rs2_busy_q <= 1'b0;
      iss_rs1_tag_q  <= '0;
      iss_rs2_tag_q  <= '0;
    end else begin
      iss_valid_q <= fire;
      illegal_q   <= ill_fire;
      if (fire) begin
        iss_rob_idx_q  <= tail_q;
        iss_func_q     <= bus.func;
        iss_rd_q       <= bus.rd;
        iss_rs1_q      <= bus.rs1;
        iss_rs2_q      <= bus.rs2;
        iss_rs1_busy_q <= src1.busy;
        iss_rs2_busy_q <= src2.busy;
        iss_rs1_tag_q  <= ROB_IW'(src1.tag);
        iss_rs2_tag_q  <= ROB_IW'(src2.tag);
      end
    end
  end

  assign bus.inst_ready   = inst_ready;
  assign bus.stall        = bus.inst_valid && !inst_ready;
  assign bus.iss_valid    = iss_valid_q;
  assign bus.iss_rob_idx  = iss_rob_idx_q;
  assign bus.iss_func     = iss_func_q;
  assign bus.iss_rd       = iss_rd_q;
  assign bus.iss_rs1      = iss_rs1_q;
  assign bus.iss_rs2      = iss_rs2_q;
  assign bus.iss_rs1_busy = iss_rs1_busy_q;
  assign bus.iss_rs2_busy = iss_rs2_busy_q;
  assign bus.iss_rs1_tag  = iss_rs1_tag_q;
  assign bus.iss_rs2_tag  = iss_rs2_tag_q;
  assign bus.illegal_op   = illegal_q;
  assign bus.rob_head     = head_q;
  assign bus.rob_tail     = tail_q;
  assign bus.rob_count    = count_q;

endmodule

// File: tb/tb_tomasulo_issue_unit.sv
// Self-checking bench for tomasulo_issue_unit with a reference model and issue scoreboard.
module tb_tomasulo_issue_unit;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  tomasulo_issue_unit_if #(.ROB_IW(3), .REG_W(4), .FUNC_W(4)) bus ();

  tomasulo_issue_unit #(
    .ROB_DEPTH (8),
    .NUM_REGS  (16),
    .FUNC_W    (4),
    .ADD_RS    (2),
    .MUL_RS    (2)
  ) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         idx;
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    bit         b1;
    bit         b2;
    int         t1;
    int         t2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state
  int m_head, m_tail, m_count, m_add, m_mul;
  bit m_busy[16];
  int m_tag[16];
  int m_rob_rd[8];

  function automatic int cls_of(input logic [3:0] f);
    if (f == 4'd0 || f == 4'd1) return 0;
    if (f == 4'd2 || f == 4'd3) return 1;
    return 2;
  endfunction

  task automatic m_reset();
    m_head = 0; m_tail = 0; m_count = 0; m_add = 0; m_mul = 0;
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 1'b0;
      m_tag[i] = 0;
    end
  endtask

  // Apply the current inputs for one clock, predicting and checking every output.
  task automatic tick();
    int c;
    bit rdy, fire, ill, commit, inc;
    int crd;
    exp_t e;
    #1;
    c = cls_of(bus.func);
    if (bus.flush) rdy = 1'b0;
    else if (c == 2) rdy = 1'b1;
    else if (c == 0) rdy = (m_count < 8) && (m_add < 2);
    else rdy = (m_count < 8) && (m_mul < 2);
    checks++;
    if (bus.inst_ready !== rdy) $display("FAIL inst_ready: got %b want %b", bus.inst_ready, rdy);
    else passes++;
    checks++;
    if (bus.stall !== (bus.inst_valid & ~rdy))
      $display("FAIL stall: got %b want %b", bus.stall, bus.inst_valid & ~rdy);
    else passes++;
    fire   = bus.inst_valid && rdy && (c != 2);
    ill    = bus.inst_valid && rdy && (c == 2);
    commit = bus.commit_valid && (m_count > 0) && !bus.flush;
    if (fire) begin
      e.idx = m_tail; e.func = bus.func; e.rd = bus.rd; e.rs1 = bus.rs1; e.rs2 = bus.rs2;
      e.b1 = m_busy[bus.rs1]; e.t1 = m_tag[bus.rs1];
      e.b2 = m_busy[bus.rs2]; e.t2 = m_tag[bus.rs2];
      sb.push_back(e);
    end
    if (bus.flush) begin
      m_head = 0; m_tail = 0; m_count = 0; m_add = 0; m_mul = 0;
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    end else begin
      if (commit) begin
        crd = m_rob_rd[m_head];
        if (m_tag[crd] == m_head) m_busy[crd] = 1'b0;
        m_head = (m_head + 1) % 8;
      end
      if (fire) begin
        m_rob_rd[m_tail] = bus.rd;
        m_busy[bus.rd] = 1'b1;
        m_tag[bus.rd] = m_tail;
        m_tail = (m_tail + 1) % 8;
      end
      m_count = m_count + int'(fire) - int'(commit);
      inc = fire && (c == 0);
      if (inc && !bus.add_rel) m_add++;
      else if (!inc && bus.add_rel && m_add > 0) m_add--;
      inc = fire && (c == 1);
      if (inc && !bus.mul_rel) m_mul++;
      else if (!inc && bus.mul_rel && m_mul > 0) m_mul--;
    end
    @(posedge clk1);
    #1;
    checks++;
    if (bus.iss_valid !== fire) $display("FAIL iss_valid: got %b want %b", bus.iss_valid, fire);
    else passes++;
    if (fire && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.iss_rob_idx !== 3'(e.idx) || bus.iss_func !== e.func || bus.iss_rd !== e.rd ||
          bus.iss_rs1 !== e.rs1 || bus.iss_rs2 !== e.rs2)
        $display("FAIL bundle: got idx%0d f%0d rd%0d s%0d/%0d want idx%0d f%0d rd%0d s%0d/%0d",
                 bus.iss_rob_idx, bus.iss_func, bus.iss_rd, bus.iss_rs1, bus.iss_rs2,
                 e.idx, e.func, e.rd, e.rs1, e.rs2);
      else passes++;
      checks++;
      if (bus.iss_rs1_busy !== e.b1 || (e.b1 && bus.iss_rs1_tag !== 3'(e.t1)))
        $display("FAIL rs1_dep: got busy%b tag%0d want busy%b tag%0d",
                 bus.iss_rs1_busy, bus.iss_rs1_tag, e.b1, e.t1);
      else passes++;
      checks++;
      if (bus.iss_rs2_busy !== e.b2 || (e.b2 && bus.iss_rs2_tag !== 3'(e.t2)))
        $display("FAIL rs2_dep: got busy%b tag%0d want busy%b tag%0d",
                 bus.iss_rs2_busy, bus.iss_rs2_tag, e.b2, e.t2);
      else passes++;
    end
    checks++;
    if (bus.illegal_op !== ill) $display("FAIL illegal_op: got %b want %b", bus.illegal_op, ill);
    else passes++;
    checks++;
    if (bus.rob_count !== 4'(m_count) || bus.rob_head !== 3'(m_head) ||
        bus.rob_tail !== 3'(m_tail))
      $display("FAIL rob_ptrs: got cnt%0d h%0d t%0d want cnt%0d h%0d t%0d",
               bus.rob_count, bus.rob_head, bus.rob_tail, m_count, m_head, m_tail);
    else passes++;
  endtask

  task automatic step(input bit v, input logic [3:0] f, input logic [3:0] rd,
                      input logic [3:0] r1, input logic [3:0] r2,
                      input bit ar, input bit mr, input bit cv, input bit fl);
    bus.inst_valid = v; bus.func = f; bus.rd = rd; bus.rs1 = r1; bus.rs2 = r2;
    bus.add_rel = ar; bus.mul_rel = mr; bus.commit_valid = cv; bus.flush = fl;
    tick();
  endtask

  task automatic idle(input bit ar, input bit mr, input bit cv, input bit fl);
    step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, ar, mr, cv, fl);
  endtask

  task automatic test_reset();
    bus.inst_valid = 0; bus.func = 0; bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus.add_rel = 0; bus.mul_rel = 0; bus.commit_valid = 0; bus.flush = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    checks++;
    if (bus.iss_valid !== 1'b0 || bus.illegal_op !== 1'b0 || bus.stall !== 1'b0)
      $display("FAIL reset_pulses: got v%b i%b s%b want 000",
               bus.iss_valid, bus.illegal_op, bus.stall);
    else passes++;
    checks++;
    if (bus.rob_count !== 4'd0 || bus.rob_head !== 3'd0 || bus.rob_tail !== 3'd0)
      $display("FAIL reset_ptrs: got cnt%0d h%0d t%0d want 0 0 0",
               bus.rob_count, bus.rob_head, bus.rob_tail);
    else passes++;
    checks++;
    if (bus.inst_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.inst_ready);
    else passes++;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_basic();
    step(1, 4'd0, 4'd3, 4'd1, 4'd2, 0, 0, 0, 0);  // ADD r3 = r1 + r2
    checks++;
    if (bus.iss_rob_idx !== 3'd0 || bus.iss_rs1_busy !== 1'b0 || bus.iss_rs2_busy !== 1'b0 ||
        bus.rob_count !== 4'd1)
      $display("FAIL first_add: got idx%0d b%b%b cnt%0d want idx0 b00 cnt1",
               bus.iss_rob_idx, bus.iss_rs1_busy, bus.iss_rs2_busy, bus.rob_count);
    else passes++;
    step(1, 4'd1, 4'd4, 4'd3, 4'd3, 0, 0, 0, 0);  // SUB r4 = r3 - r3
    checks++;
    if (bus.iss_rob_idx !== 3'd1 || bus.iss_rs1_busy !== 1'b1 || bus.iss_rs2_busy !== 1'b1 ||
        bus.iss_rs1_tag !== 3'd0 || bus.iss_rs2_tag !== 3'd0)
      $display("FAIL dep_add: got idx%0d b%b%b t%0d/%0d want idx1 b11 t0/0",
               bus.iss_rob_idx, bus.iss_rs1_busy, bus.iss_rs2_busy,
               bus.iss_rs1_tag, bus.iss_rs2_tag);
    else passes++;
  endtask

  task automatic test_rs_stall();
    idle(0, 0, 0, 1);
    step(1, 4'd0, 4'd1, 4'd0, 4'd0, 0, 0, 0, 0);
    step(1, 4'd0, 4'd2, 4'd0, 4'd0, 0, 0, 0, 0);
    step(1, 4'd0, 4'd3, 4'd1, 4'd2, 0, 0, 0, 0);  // stalls: both add slots taken
    checks++;
    if (bus.stall !== 1'b1) $display("FAIL add_stall: got %b want 1", bus.stall);
    else passes++;
    step(1, 4'd0, 4'd3, 4'd1, 4'd2, 1, 0, 0, 0);  // release seen next cycle only
    step(1, 4'd0, 4'd3, 4'd1, 4'd2, 0, 0, 0, 0);  // now issues
    checks++;
    if (bus.iss_valid !== 1'b1 || bus.iss_rob_idx !== 3'd2)
      $display("FAIL add_after_rel: got v%b idx%0d want v1 idx2", bus.iss_valid, bus.iss_rob_idx);
    else passes++;
  endtask

  task automatic test_fill_wrap();
    idle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 4'd0, 4'(i + 1), 4'd0, 4'(i), 1, 0, 0, 0);
      else            step(1, 4'd3, 4'(i + 1), 4'(i), 4'd0, 0, 1, 0, 0);
    end
    step(1, 4'd0, 4'd9, 4'd1, 4'd2, 1, 0, 0, 0);  // ROB full
    checks++;
    if (bus.rob_count !== 4'd8 || bus.rob_tail !== bus.rob_head)
      $display("FAIL full: got cnt%0d h%0d t%0d want cnt8 h==t",
               bus.rob_count, bus.rob_head, bus.rob_tail);
    else passes++;
    idle(0, 0, 1, 0);
    step(1, 4'd0, 4'd9, 4'd8, 4'd2, 1, 0, 1, 0);  // commit and issue together
    checks++;
    if (bus.iss_rob_idx !== 3'd0 || bus.rob_count !== 4'd7)
      $display("FAIL wrap: got idx%0d cnt%0d want idx0 cnt7", bus.iss_rob_idx, bus.rob_count);
    else passes++;
    step(1, 4'd1, 4'd10, 4'd9, 4'd9, 1, 0, 0, 0);
  endtask

  task automatic test_rename_preserve();
    idle(0, 0, 0, 1);
    step(1, 4'd0, 4'd1, 4'd0, 4'd0, 1, 0, 0, 0);
    step(1, 4'd0, 4'd2, 4'd0, 4'd0, 1, 0, 0, 0);
    step(1, 4'd2, 4'd5, 4'd1, 4'd2, 0, 0, 0, 0);  // MUL r5 -> idx2
    step(1, 4'd0, 4'd5, 4'd0, 4'd0, 1, 0, 0, 0);  // ADD r5 -> idx3
    idle(0, 0, 1, 0);
    idle(0, 0, 1, 0);
    idle(0, 0, 1, 0);                             // commit idx2: r5 stays on idx3
    step(1, 4'd0, 4'd6, 4'd5, 4'd0, 0, 0, 0, 0);
    checks++;
    if (bus.iss_rs1_busy !== 1'b1 || bus.iss_rs1_tag !== 3'd3)
      $display("FAIL younger_kept: got b%b t%0d want b1 t3", bus.iss_rs1_busy, bus.iss_rs1_tag);
    else passes++;
    idle(0, 0, 1, 0);                             // commit idx3: r5 free
    step(1, 4'd0, 4'd7, 4'd5, 4'd5, 0, 0, 0, 0);
    checks++;
    if (bus.iss_rs1_busy !== 1'b0 || bus.iss_rs2_busy !== 1'b0)
      $display("FAIL r5_free: got b%b%b want b00", bus.iss_rs1_busy, bus.iss_rs2_busy);
    else passes++;
    step(1, 4'd2, 4'd6, 4'd6, 4'd0, 0, 0, 1, 0);  // commit r6 while renaming r6 again
    checks++;
    if (bus.iss_rs1_busy !== 1'b1 || bus.iss_rs1_tag !== 3'd4)
      $display("FAIL same_cycle_commit: got b%b t%0d want b1 t4",
               bus.iss_rs1_busy, bus.iss_rs1_tag);
    else passes++;
    idle(1, 1, 0, 0);
    step(1, 4'd3, 4'd8, 4'd6, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic test_illegal_flush();
    step(1, 4'hF, 4'd9, 4'd1, 4'd1, 0, 0, 0, 0);
    checks++;
    if (bus.illegal_op !== 1'b1 || bus.iss_valid !== 1'b0)
      $display("FAIL illegal: got i%b v%b want i1 v0", bus.illegal_op, bus.iss_valid);
    else passes++;
    idle(0, 0, 0, 0);
    step(1, 4'd2, 4'd9, 4'd6, 4'd8, 1, 1, 1, 1);  // flush drops everything else
    checks++;
    if (bus.rob_count !== 4'd0 || bus.rob_head !== 3'd0 || bus.rob_tail !== 3'd0 ||
        bus.iss_valid !== 1'b0)
      $display("FAIL flush: got cnt%0d h%0d t%0d v%b want 0 0 0 0",
               bus.rob_count, bus.rob_head, bus.rob_tail, bus.iss_valid);
    else passes++;
    idle(0, 0, 1, 0);                             // commit on empty ROB is ignored
    step(1, 4'd0, 4'd1, 4'd6, 4'd8, 0, 0, 0, 0);
    checks++;
    if (bus.iss_rob_idx !== 3'd0 || bus.iss_rs1_busy !== 1'b0 || bus.iss_rs2_busy !== 1'b0)
      $display("FAIL post_flush: got idx%0d b%b%b want idx0 b00",
               bus.iss_rob_idx, bus.iss_rs1_busy, bus.iss_rs2_busy);
    else passes++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    @(posedge clk1);
    #1;
    test_basic();
    test_rs_stall();
    test_fill_wrap();
    test_rename_preserve();
    test_illegal_flush();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
